// File: rtl/axil_pkg.sv
// Shared response codes, FSM encodings and the debug view for the AXI-lite register file.
package axil_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic {WR_IDLE = 1'b0, WR_RESP = 1'b1} wr_state_t;
   typedef enum logic {RD_IDLE = 1'b0, RD_RESP = 1'b1} rd_state_t;

   typedef struct packed {
      wr_state_t wr_state;
      logic      aw_held;
      logic      w_held;
      rd_state_t rd_state;
   } axil_dbg_t;

   // Width of a bank-local register index, wide enough for the larger bank.
   function automatic int idx_width(input int num_rw, input int num_ro);
      int m;
      m = (num_rw > num_ro) ? num_rw : num_ro;
      return (m > 1) ? $clog2(m) : 1;
   endfunction

endpackage

// File: rtl/axil_regfile_if.sv
// AXI-lite bus bundle. Handshake rule on every channel: a beat transfers on the rising
// clk edge where valid and ready are both 1; valid, once raised, holds its payload until then.
interface axil_regfile_if;

   logic [31:0] awaddr;
   logic [2:0]  awprot;
   logic        awvalid;
   logic        awready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wvalid;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;
   logic [31:0] araddr;
   logic [2:0]  arprot;
   logic        arvalid;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready;

   modport slave (
      input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
             araddr, arprot, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

   modport master (
      output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
             araddr, arprot, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

endinterface

// File: rtl/axil_regfile_decode.sv
// Maps a word index onto the RW bank, the RO bank, or the unmapped remainder of the window,
// and gives the index local to whichever bank it hits.
module axil_regfile_decode
   import axil_pkg::*;
#(
   parameter int NUM_RW     = 8,
   parameter int NUM_RO     = 8,
   parameter int ADDR_WIDTH = 11,
   parameter int LW         = idx_width(NUM_RW, NUM_RO)
) (
   input  logic [ADDR_WIDTH-3:0] word_idx,
   output logic                  is_rw,
   output logic                  is_ro,
   output logic                  unmapped,
   output logic [LW-1:0]         local_idx
);

   logic [31:0] idx32;

   assign idx32 = 32'(word_idx);

   always_comb begin
      is_rw     = idx32 < 32'(NUM_RW);
      is_ro     = !is_rw && (idx32 < 32'(NUM_RW + NUM_RO));
      unmapped  = !is_rw && !is_ro;
      local_idx = '0;
      for (int i = 0; i < NUM_RW; i++) begin
         if (idx32 == 32'(i)) local_idx = LW'(i);
      end
      for (int i = 0; i < NUM_RO; i++) begin
         if (idx32 == 32'(NUM_RW + i)) local_idx = LW'(i);
      end
   end

endmodule

// File: rtl/axil_regfile.sv
// AXI-lite responder with NUM_RW byte-strobed control registers and NUM_RO status registers.
// Write and read paths are independent two-state machines; all readies are registered.
module axil_regfile
   import axil_pkg::*;
#(
   parameter int NUM_RW     = 8,
   parameter int NUM_RO     = 8,
   parameter int ADDR_WIDTH = 11
) (
   input  logic                   clk,
   input  logic                   resetn,
   axil_regfile_if.slave          s_axil,
   output logic [32*NUM_RW-1:0]   ctrl_regs,
   output logic [NUM_RW-1:0]      ctrl_wr_pulse,
   input  logic [32*NUM_RO-1:0]   status_regs,
   output axil_dbg_t              dbg
);

   localparam int LW = idx_width(NUM_RW, NUM_RO);
   localparam int IW = ADDR_WIDTH - 2;

   // ---------------- write path ----------------
   wr_state_t         wr_state, wr_state_n;
   logic              aw_held, w_held, aw_held_n, w_held_n;
   logic              awready_q, wready_q, awready_n, wready_n;
   logic [IW-1:0]     aw_idx_q;
   logic [31:0]       wdata_q;
   logic [3:0]        wstrb_q;
   logic [1:0]        bresp_q;
   logic              aw_hs, w_hs, commit;
   logic [IW-1:0]     wr_idx;
   logic [31:0]       wr_data;
   logic [3:0]        wr_strb;
   logic              wr_is_rw, wr_is_ro, wr_unmapped;
   logic [LW-1:0]     wr_local;
   logic [NUM_RW-1:0] wr_sel;
   logic [31:0]       ctrl_q [NUM_RW];

   axil_regfile_decode #(
      .NUM_RW(NUM_RW), .NUM_RO(NUM_RO), .ADDR_WIDTH(ADDR_WIDTH), .LW(LW)
   ) u_wr_decode (
      .word_idx(wr_idx), .is_rw(wr_is_rw), .is_ro(wr_is_ro),
      .unmapped(wr_unmapped), .local_idx(wr_local)
   );

   // A beat arriving in the commit cycle is used directly, bypassing the holding flops.
   always_comb begin
      aw_hs   = s_axil.awvalid && awready_q;
      w_hs    = s_axil.wvalid && wready_q;
      wr_idx  = aw_held ? aw_idx_q : s_axil.awaddr[ADDR_WIDTH-1:2];
      wr_data = w_held ? wdata_q : s_axil.wdata;
      wr_strb = w_held ? wstrb_q : s_axil.wstrb;
      commit  = (wr_state == WR_IDLE) && (aw_held || aw_hs) && (w_held || w_hs);
      wr_sel  = '0;
      for (int i = 0; i < NUM_RW; i++) begin
         wr_sel[i] = commit && wr_is_rw && (wr_local == LW'(i));
      end
   end

   always_comb begin
      wr_state_n = wr_state;
      aw_held_n  = aw_held;
      w_held_n   = w_held;
      case (wr_state)
         WR_IDLE: begin
            if (commit) begin
               wr_state_n = WR_RESP;
               aw_held_n  = 1'b0;
               w_held_n   = 1'b0;
            end else begin
               aw_held_n = aw_held || aw_hs;
               w_held_n  = w_held || w_hs;
            end
         end
         WR_RESP: begin
            if (s_axil.bready) wr_state_n = WR_IDLE;
         end
         default: wr_state_n = WR_IDLE;
      endcase
      awready_n = (wr_state_n == WR_IDLE) && !aw_held_n;
      wready_n  = (wr_state_n == WR_IDLE) && !w_held_n;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_state      <= WR_IDLE;
         aw_held       <= 1'b0;
         w_held        <= 1'b0;
         awready_q     <= 1'b0;
         wready_q      <= 1'b0;
         aw_idx_q      <= '0;
         wdata_q       <= '0;
         wstrb_q       <= '0;
         bresp_q       <= RESP_OKAY;
         ctrl_wr_pulse <= '0;
         for (int i = 0; i < NUM_RW; i++) ctrl_q[i] <= '0;
      end else begin
         wr_state      <= wr_state_n;
         aw_held       <= aw_held_n;
         w_held        <= w_held_n;
         awready_q     <= awready_n;
         wready_q      <= wready_n;
         ctrl_wr_pulse <= wr_sel;
         if (aw_hs) aw_idx_q <= s_axil.awaddr[ADDR_WIDTH-1:2];
         if (w_hs) begin
            wdata_q <= s_axil.wdata;
            wstrb_q <= s_axil.wstrb;
         end
         if (commit) bresp_q <= wr_is_rw ? RESP_OKAY : RESP_SLVERR;
         for (int i = 0; i < NUM_RW; i++) begin
            for (int k = 0; k < 4; k++) begin
               if (wr_sel[i] && wr_strb[k]) ctrl_q[i][8*k +: 8] <= wr_data[8*k +: 8];
            end
         end
      end
   end

   assign s_axil.awready = awready_q;
   assign s_axil.wready  = wready_q;
   assign s_axil.bvalid  = (wr_state == WR_RESP);
   assign s_axil.bresp   = bresp_q;

   // ---------------- read path ----------------
   rd_state_t     rd_state, rd_state_n;
   logic          arready_q, ar_hs;
   logic [31:0]   rdata_q, rd_mux;
   logic [1:0]    rresp_q;
   logic          rd_is_rw, rd_is_ro, rd_unmapped;
   logic [LW-1:0] rd_local;

   axil_regfile_decode #(
      .NUM_RW(NUM_RW), .NUM_RO(NUM_RO), .ADDR_WIDTH(ADDR_WIDTH), .LW(LW)
   ) u_rd_decode (
      .word_idx(s_axil.araddr[ADDR_WIDTH-1:2]), .is_rw(rd_is_rw), .is_ro(rd_is_ro),
      .unmapped(rd_unmapped), .local_idx(rd_local)
   );

   // ctrl_q is read before any same-edge write lands, so a colliding read sees the old value.
   always_comb begin
      ar_hs  = s_axil.arvalid && arready_q;
      rd_mux = '0;
      for (int i = 0; i < NUM_RW; i++) begin
         if (rd_is_rw && (rd_local == LW'(i))) rd_mux = ctrl_q[i];
      end
      for (int i = 0; i < NUM_RO; i++) begin
         if (rd_is_ro && (rd_local == LW'(i))) rd_mux = status_regs[32*i +: 32];
      end
      rd_state_n = rd_state;
      case (rd_state)
         RD_IDLE: if (ar_hs) rd_state_n = RD_RESP;
         RD_RESP: if (s_axil.rready) rd_state_n = RD_IDLE;
         default: rd_state_n = RD_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rd_state  <= RD_IDLE;
         arready_q <= 1'b0;
         rdata_q   <= '0;
         rresp_q   <= RESP_OKAY;
      end else begin
         rd_state  <= rd_state_n;
         arready_q <= (rd_state_n == RD_IDLE);
         if (ar_hs) begin
            rdata_q <= rd_mux;
            rresp_q <= rd_unmapped ? RESP_SLVERR : RESP_OKAY;
         end
      end
   end

   assign s_axil.arready = arready_q;
   assign s_axil.rvalid  = (rd_state == RD_RESP);
   assign s_axil.rdata   = rdata_q;
   assign s_axil.rresp   = rresp_q;

   for (genvar g = 0; g < NUM_RW; g++) begin : g_ctrl_out
      assign ctrl_regs[32*g +: 32] = ctrl_q[g];
   end

   assign dbg = '{wr_state: wr_state, aw_held: aw_held, w_held: w_held, rd_state: rd_state};

   logic unused_ok;
   assign unused_ok = &{1'b0, s_axil.awprot, s_axil.arprot,
                        s_axil.awaddr[31:ADDR_WIDTH], s_axil.awaddr[1:0],
                        s_axil.araddr[31:ADDR_WIDTH], s_axil.araddr[1:0],
                        wr_is_ro, wr_unmapped};

endmodule

// File: tb/tb_axil_regfile.sv
// Bench for axil_regfile: a vector table run through bus tasks, plus hand-built
// sequences for handshake ordering, backpressure, read/write collision and mid-flight reset.
module tb_axil_regfile;
   import axil_pkg::*;

   localparam int NUM_RW     = 8;
   localparam int NUM_RO     = 8;
   localparam int ADDR_WIDTH = 11;
   localparam int W          = 34;
   localparam int NV         = 17;

   logic clk = 1'b0;
   logic resetn;
   always #5 clk = ~clk;

   axil_regfile_if bus();
   logic [32*NUM_RW-1:0] ctrl_regs;
   logic [NUM_RW-1:0]    ctrl_wr_pulse;
   logic [32*NUM_RO-1:0] status_regs;
   axil_dbg_t            dbg;

   axil_regfile #(.NUM_RW(NUM_RW), .NUM_RO(NUM_RO), .ADDR_WIDTH(ADDR_WIDTH)) dut (
      .clk(clk), .resetn(resetn), .s_axil(bus),
      .ctrl_regs(ctrl_regs), .ctrl_wr_pulse(ctrl_wr_pulse),
      .status_regs(status_regs), .dbg(dbg)
   );

   int checks   = 0;
   int failures = 0;
   logic [W-1:0] exp_q[$];

   typedef struct {
      logic        is_wr;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
      logic [1:0]  exp_resp;
      logic [31:0] exp_rdata;
   } vec_t;
   vec_t vecs [NV];

   // ---------------- clock / reset helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] ctrl_word(input int i);
      return ctrl_regs[32*i +: 32];
   endfunction

   // ---------------- driver tasks ----------------
   task automatic write_txn(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input logic [1:0] resp);
      int   n;
      logic aw_hs, w_hs, aw_done, w_done;
      exp_q.push_back({resp, 32'h0});
      bus.awaddr  = addr;
      bus.wdata   = data;
      bus.wstrb   = strb;
      bus.awvalid = 1'b1;
      bus.wvalid  = 1'b1;
      aw_done = 1'b0;
      w_done  = 1'b0;
      n = 0;
      while (!(aw_done && w_done) && n < 20) begin
         aw_hs = bus.awvalid && bus.awready;
         w_hs  = bus.wvalid && bus.wready;
         tick();
         if (aw_hs) begin aw_done = 1'b1; bus.awvalid = 1'b0; end
         if (w_hs)  begin w_done  = 1'b1; bus.wvalid  = 1'b0; end
         n++;
      end
      bus.awvalid = 1'b0;
      bus.wvalid  = 1'b0;
      check("aw_w_accepted", {63'h0, aw_done && w_done}, 64'h1);
   endtask

   task automatic read_txn(input logic [31:0] addr, input logic [1:0] resp, input logic [31:0] data);
      int   n;
      logic hs, done;
      exp_q.push_back({resp, data});
      bus.araddr  = addr;
      bus.arvalid = 1'b1;
      done = 1'b0;
      n = 0;
      while (!done && n < 20) begin
         hs = bus.arvalid && bus.arready;
         tick();
         if (hs) begin done = 1'b1; bus.arvalid = 1'b0; end
         n++;
      end
      bus.arvalid = 1'b0;
      check("ar_accepted", {63'h0, done}, 64'h1);
   endtask

   // ---------------- scoreboard collectors ----------------
   task automatic collect_b(input string name);
      int n = 0;
      logic [W-1:0] exp;
      bus.bready = 1'b1;
      while (!bus.bvalid && n < 20) begin tick(); n++; end
      check({name, "_bvalid"}, {63'h0, bus.bvalid}, 64'h1);
      if (exp_q.size() > 0) begin
         exp = exp_q.pop_front();
         if (bus.bvalid) check({name, "_bresp"}, {30'h0, bus.bresp, 32'h0}, {30'h0, exp});
      end
      tick();
      bus.bready = 1'b0;
   endtask

   task automatic collect_r(input string name);
      int n = 0;
      logic [W-1:0] exp;
      bus.rready = 1'b1;
      while (!bus.rvalid && n < 20) begin tick(); n++; end
      check({name, "_rvalid"}, {63'h0, bus.rvalid}, 64'h1);
      if (exp_q.size() > 0) begin
         exp = exp_q.pop_front();
         if (bus.rvalid) check({name, "_rresp_rdata"}, {30'h0, bus.rresp, bus.rdata}, {30'h0, exp});
      end
      tick();
      bus.rready = 1'b0;
   endtask

   // ---------------- main sequence ----------------
   initial begin
      logic stable_ok;

      resetn      = 1'b0;
      bus.awaddr  = '0; bus.awprot = '0; bus.awvalid = 1'b0;
      bus.wdata   = '0; bus.wstrb  = '0; bus.wvalid  = 1'b0;
      bus.bready  = 1'b0;
      bus.araddr  = '0; bus.arprot = '0; bus.arvalid = 1'b0;
      bus.rready  = 1'b0;
      for (int i = 0; i < NUM_RO; i++) status_regs[32*i +: 32] = 32'h5000_0000 + i;

      vecs[0]  = '{1'b1, 32'h000, 32'hDEAD_BEEF, 4'hF, RESP_OKAY,   32'h0};
      vecs[1]  = '{1'b0, 32'h000, 32'h0,         4'h0, RESP_OKAY,   32'hDEAD_BEEF};
      vecs[2]  = '{1'b1, 32'h008, 32'hFFFF_FFFF, 4'h5, RESP_OKAY,   32'h0};
      vecs[3]  = '{1'b0, 32'h008, 32'h0,         4'h0, RESP_OKAY,   32'h00FF_00FF};
      vecs[4]  = '{1'b1, 32'h00A, 32'h1234_5678, 4'h0, RESP_OKAY,   32'h0};
      vecs[5]  = '{1'b0, 32'h00B, 32'h0,         4'h0, RESP_OKAY,   32'h00FF_00FF};
      vecs[6]  = '{1'b1, 32'h01C, 32'h0000_AB00, 4'h2, RESP_OKAY,   32'h0};
      vecs[7]  = '{1'b0, 32'h01C, 32'h0,         4'h0, RESP_OKAY,   32'h0000_AB00};
      vecs[8]  = '{1'b0, 32'h03C, 32'h0,         4'h0, RESP_OKAY,   32'h5000_0007};
      vecs[9]  = '{1'b0, 32'h020, 32'h0,         4'h0, RESP_OKAY,   32'h5000_0000};
      vecs[10] = '{1'b1, 32'h024, 32'hFFFF_FFFF, 4'hF, RESP_SLVERR, 32'h0};
      vecs[11] = '{1'b0, 32'h024, 32'h0,         4'h0, RESP_OKAY,   32'h5000_0001};
      vecs[12] = '{1'b1, 32'h040, 32'h1111_1111, 4'hF, RESP_SLVERR, 32'h0};
      vecs[13] = '{1'b0, 32'h040, 32'h0,         4'h0, RESP_SLVERR, 32'h0};
      vecs[14] = '{1'b0, 32'h7FC, 32'h0,         4'h0, RESP_SLVERR, 32'h0};
      vecs[15] = '{1'b0, 32'h800, 32'h0,         4'h0, RESP_OKAY,   32'hDEAD_BEEF};
      vecs[16] = '{1'b0, 32'h400, 32'h0,         4'h0, RESP_SLVERR, 32'h0};

      // Reset state and ready rise
      repeat (3) tick();
      check("rst_awready", {63'h0, bus.awready}, 64'h0);
      check("rst_wready",  {63'h0, bus.wready},  64'h0);
      check("rst_arready", {63'h0, bus.arready}, 64'h0);
      check("rst_bvalid",  {63'h0, bus.bvalid},  64'h0);
      check("rst_rvalid",  {63'h0, bus.rvalid},  64'h0);
      check("rst_ctrl_zero", {63'h0, ctrl_regs == '0}, 64'h1);
      resetn = 1'b1;
      check("rel_awready_still_low", {63'h0, bus.awready}, 64'h0);
      tick();
      check("rel_readies_high", {61'h0, bus.awready, bus.wready, bus.arready}, 64'h7);
      check("rel_ctrl_zero", {63'h0, ctrl_regs == '0}, 64'h1);

      // AW and W together to reg1
      exp_q.push_back({RESP_OKAY, 32'h0});
      bus.awaddr = 32'h004; bus.wdata = 32'hA5A5_A5A5; bus.wstrb = 4'hF;
      bus.awvalid = 1'b1; bus.wvalid = 1'b1;
      tick();
      bus.awvalid = 1'b0; bus.wvalid = 1'b0;
      check("a_bvalid_latency", {63'h0, bus.bvalid}, 64'h1);
      check("a_pulse_on", {56'h0, ctrl_wr_pulse}, 64'h02);
      check("a_reg1", {32'h0, ctrl_word(1)}, 64'hA5A5_A5A5);
      tick();
      check("a_pulse_off", {56'h0, ctrl_wr_pulse}, 64'h00);
      collect_b("a");
      check("a_readies_back", {62'h0, bus.awready, bus.wready}, 64'h3);

      // W first with partial strobes, AW later, bready held off
      exp_q.push_back({RESP_OKAY, 32'h0});
      bus.wdata = 32'h1122_3344; bus.wstrb = 4'h3; bus.wvalid = 1'b1;
      tick();
      bus.wvalid = 1'b0;
      check("b_w_held", {62'h0, bus.awready, bus.wready}, 64'h2);
      tick();
      tick();
      bus.awaddr = 32'h004; bus.awvalid = 1'b1;
      tick();
      bus.awvalid = 1'b0;
      check("b_dbg_state", {63'h0, dbg.wr_state}, {63'h0, WR_RESP});
      stable_ok = 1'b1;
      for (int c = 0; c < 4; c++) begin
         if (!(bus.bvalid && bus.bresp == RESP_OKAY && !bus.awready && !bus.wready)) stable_ok = 1'b0;
         tick();
      end
      check("b_resp_stable", {63'h0, stable_ok}, 64'h1);
      collect_b("b");
      check("b_reg1", {32'h0, ctrl_word(1)}, 64'hA5A5_3344);

      // Table-driven vectors
      for (int i = 0; i < NV; i++) begin
         if (vecs[i].is_wr) begin
            write_txn(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].exp_resp);
            collect_b($sformatf("vec%0d", i));
         end else begin
            read_txn(vecs[i].addr, vecs[i].exp_resp, vecs[i].exp_rdata);
            collect_r($sformatf("vec%0d", i));
         end
         repeat ($urandom_range(0, 2)) tick();
      end
      check("tbl_reg0", {32'h0, ctrl_word(0)}, 64'hDEAD_BEEF);
      check("tbl_reg2", {32'h0, ctrl_word(2)}, 64'h00FF_00FF);
      check("tbl_reg7", {32'h0, ctrl_word(7)}, 64'h0000_AB00);

      // Status sampled at the AR edge, changed right after
      status_regs[31:0] = 32'hCAFE_F00D;
      exp_q.push_back({RESP_OKAY, 32'hCAFE_F00D});
      bus.araddr = 32'h020; bus.arvalid = 1'b1;
      tick();
      bus.arvalid = 1'b0;
      status_regs[31:0] = 32'h0;
      check("c_rvalid_latency", {63'h0, bus.rvalid}, 64'h1);
      collect_r("c");
      check("c_arready_back", {63'h0, bus.arready}, 64'h1);
      status_regs[31:0] = 32'h5000_0000;

      // Same-edge write and read of reg0
      exp_q.push_back({RESP_OKAY, 32'h0});
      exp_q.push_back({RESP_OKAY, 32'hDEAD_BEEF});
      bus.awaddr = 32'h000; bus.wdata = 32'h1234_5678; bus.wstrb = 4'hF;
      bus.araddr = 32'h000;
      bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.arvalid = 1'b1;
      tick();
      bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
      collect_b("d_wr");
      collect_r("d_rd_old");
      read_txn(32'h000, RESP_OKAY, 32'h1234_5678);
      collect_r("d_rd_new");

      // Reset while a write response is pending
      write_txn(32'h00C, 32'h0BAD_F00D, 4'hF, RESP_OKAY);
      check("e_bvalid_before", {63'h0, bus.bvalid}, 64'h1);
      #2 resetn = 1'b0;
      #1;
      check("e_bvalid_drop", {63'h0, bus.bvalid}, 64'h0);
      check("e_ctrl_zero", {63'h0, ctrl_regs == '0}, 64'h1);
      check("e_awready_low", {63'h0, bus.awready}, 64'h0);
      exp_q.delete();
      tick();
      tick();
      resetn = 1'b1;
      tick();
      stable_ok = 1'b1;
      for (int c = 0; c < 3; c++) begin
         if (bus.bvalid || bus.rvalid) stable_ok = 1'b0;
         tick();
      end
      check("e_no_stale_resp", {63'h0, stable_ok}, 64'h1);
      check("e_readies_back", {61'h0, bus.awready, bus.wready, bus.arready}, 64'h7);
      check("sb_drained", 64'(exp_q.size()), 64'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      failures++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/axil_regfile.md
Name: axil_regfile

Overview:
AXI-lite responder (slave endpoint) that terminates one slave port of the interconnect.
- Implements a bank of NUM_RW read/write control registers followed by NUM_RO read-only status registers, each 32 bits.
- Honours byte strobes.
- Returns SLVERR for unmapped or read-only writes.
- Exports register contents and per-register write strobes to the fabric logic behind it.

Parameters:
NUM_RW, 8, number of RW control registers, word offsets 0..NUM_RW-1
NUM_RO, 8, number of RO status registers, word offsets NUM_RW..NUM_RW+NUM_RO-1
ADDR_WIDTH, 11, significant address bits (2048-byte window); upper awaddr/araddr bits ignored

Ports:
clk  in  1  system clock
resetn  in  1  reset; asynchronous, active-low
s_axil_awaddr  in  32  write address (byte address, window-relative)
s_axil_awprot  in  3  ignored
s_axil_awvalid  in  1  AW valid
s_axil_awready  out  1  AW ready
s_axil_wdata  in  32  write data
s_axil_wstrb  in  4  byte strobes
s_axil_wvalid  in  1  W valid
s_axil_wready  out  1  W ready
s_axil_bresp  out  2  write response
s_axil_bvalid  out  1  B valid
s_axil_bready  in  1  B ready
s_axil_araddr  in  32  read address
s_axil_arprot  in  3  ignored
s_axil_arvalid  in  1  AR valid
s_axil_arready  out  1  AR ready
s_axil_rdata  out  32  read data
s_axil_rresp  out  2  read response
s_axil_rvalid  out  1  R valid
s_axil_rready  in  1  R ready
ctrl_regs  out  32*NUM_RW  RW register contents, reg i at [32*i+31:32*i]
ctrl_wr_pulse  out  NUM_RW  one-cycle pulse when reg i is written (any strobe)
status_regs  in  32*NUM_RO  RO register sources, same packing

Behaviour:
- Reset (resetn=0, async): all outputs 0, including readies, bvalid, rvalid, ctrl_regs and ctrl_wr_pulse. All readies are registered and rise on the first clk edge after reset release.
- Word index = addr[ADDR_WIDTH-1:2]; addr[1:0] ignored.
- Write path states: WR_IDLE, WR_RESP.
  - In WR_IDLE, AW and W are accepted independently. awready is high while no address is held; wready is high while no data is held. Held address/data are captured in flops.
  - When both address and data are held, or both handshake in the same cycle, the write commits on that edge, the block moves to WR_RESP, and bvalid=1 on the next cycle. Latency: bvalid one cycle after the later of the AW/W handshakes.
  - Commit rules:
    - RW index: bytes with wstrb[k]=1 are updated; ctrl_wr_pulse[i]=1 for exactly one cycle (the bvalid-rise cycle); bresp=OKAY.
    - RO or unmapped index: no state change, no pulse, bresp=SLVERR.
    - wstrb=0 to a RW index: no change, pulse still fires, OKAY.
  - In WR_RESP, awready=wready=0 and bvalid holds with a stable bresp until bready. On the bvalid&bready edge: return to WR_IDLE with awready=wready=1 on the next cycle.
- Read path states: RD_IDLE, RD_RESP.
  - In RD_IDLE, arready=1. On the arvalid&arready edge, rdata/rresp are captured, the block moves to RD_RESP, and arready=0. rvalid=1 the next cycle.
  - Read data by index:
    - RW index: current ctrl value.
    - RO index: status_regs sampled at the AR handshake edge.
    - Unmapped index: rdata=0, rresp=SLVERR.
  - rvalid, rdata and rresp are held stable until rready. On rvalid&rready: RD_IDLE, arready=1 the next cycle. No back-to-back read without a one-cycle gap.
- Read and write paths are fully independent and may be in flight concurrently.
- Same-edge read capture and write commit to the same RW register: the read returns the pre-write value.
- Reset mid-transaction: all state is abandoned, registers return to 0, and no response is issued.

Decomposition:
- Package axil_pkg: RESP_OKAY=2'b00, RESP_SLVERR=2'b10, WR_IDLE/WR_RESP and RD_IDLE/RD_RESP state encodings.
- One sub-module, axil_regfile_decode: combinational index-to-{is_rw, is_ro, unmapped, local index} decoder. It is instantiated twice, once for the write path and once for the read path.

Test Plan:
- Reset release: awready/wready/arready go 0 -> 1 one clk later; all ctrl_regs=0; bvalid=rvalid=0.
- AW 0x004 and W 0xA5A5A5A5 with wstrb=0xF in the same cycle: bvalid next cycle, bresp=00; ctrl_regs[1]=0xA5A5A5A5; ctrl_wr_pulse[1] high for exactly 1 cycle.
- W first (0x11223344, wstrb=0x3) to reg1, AW 3 cycles later, with bready held low for 4 cycles: reg1 becomes 0xA5A53344; bvalid and bresp are stable until bready; awready=0 throughout.
- Read 0x020 with status_regs[0]=0xCAFEF00D, where status changes the cycle after the handshake: rdata=0xCAFEF00D, rresp=00, rvalid one cycle after AR.
- Write 0x020 (RO) and read 0x400 (unmapped): bresp=10 with status unchanged; rdata=0, rresp=10.
- Concurrent write 0x12345678 to reg0 on the same edge as a reg0 read: rdata equals the old value; a subsequent read returns 0x12345678. Assert resetn mid-WR_RESP: bvalid drops immediately and reg0=0.
